// File: rtl/melody_sequencer.sv
// melody_sequencer: debounces an active-low key and, on each press, plays a
// fixed 4-note melody as half-period compare values for a tone generator.
// Each note is held for NOTE_LEN cycles, with GAP_LEN silent cycles between
// notes. A press while the melody is playing aborts it.
module melody_sequencer #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int NOTE_LEN        = 12000000,
    parameter int GAP_LEN         = 1200000,
    parameter int NOTE0           = 27272,
    parameter int NOTE1           = 18202,
    parameter int NOTE2           = 15306,
    parameter int NOTE3           = 22933
) (
    input  logic        clk12MHz,
    input  logic        rst,
    input  logic        key1,
    output logic [23:0] half_period,
    output logic        tone_en,
    output logic [1:0]  note_index,
    output logic        busy,
    output logic        done
);

    localparam logic [23:0] DEB_MAX   = 24'(DEBOUNCE_CYCLES);
    localparam logic [23:0] NOTE_LAST = 24'(NOTE_LEN - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_LEN - 1);
    localparam bit          GAP_EN    = (GAP_LEN != 0);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    // Note table lookup; a zero value marks a rest.
    function automatic logic [23:0] note_val(input logic [1:0] idx);
        case (idx)
            2'd0:    note_val = 24'(NOTE0);
            2'd1:    note_val = 24'(NOTE1);
            2'd2:    note_val = 24'(NOTE2);
            default: note_val = 24'(NOTE3);
        endcase
    endfunction

    logic        key_meta, key_s;
    logic [23:0] deb_cnt;
    logic        deb_level, deb_level_q;
    logic        press;

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic [23:0] half_period_n;
    logic        tone_en_n, busy_n, done_n;
    logic [1:0]  note_index_n, idx_inc;

    // Two-flop synchronizer; idles at 1 (key released).
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key1;
            key_s    <= key_meta;
        end
    end

    // Debounce: count consecutive disagreeing cycles, accept the new level at DEBOUNCE_CYCLES.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            deb_cnt     <= '0;
            deb_level   <= 1'b1;
            deb_level_q <= 1'b1;
        end else begin
            deb_level_q <= deb_level;
            if (key_s != deb_level) begin
                if (deb_cnt == DEB_MAX) begin
                    deb_level <= key_s;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 24'd1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Only the falling edge of the debounced level is an event; release is ignored.
    assign press   = deb_level_q & ~deb_level;
    assign idx_inc = note_index + 2'd1;

    // Sequencer state and registered outputs.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            note_index  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            half_period <= half_period_n;
            tone_en     <= tone_en_n;
            note_index  <= note_index_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    // Next-state and next-output logic; an abort press outranks the end of a note.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt + 24'd1;
        half_period_n = half_period;
        tone_en_n     = tone_en;
        note_index_n  = note_index;
        busy_n        = busy;
        done_n        = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (press) begin
                    state_n       = NOTE;
                    note_index_n  = 2'd0;
                    half_period_n = note_val(2'd0);
                    tone_en_n     = (note_val(2'd0) != 24'd0);
                    busy_n        = 1'b1;
                end
            end
            NOTE, GAP: begin
                if (press) begin
                    state_n       = IDLE;
                    cnt_n         = '0;
                    half_period_n = '0;
                    tone_en_n     = 1'b0;
                    note_index_n  = 2'd0;
                    busy_n        = 1'b0;
                end else if (state == NOTE && cnt == NOTE_LAST) begin
                    cnt_n = '0;
                    if (note_index == 2'd3) begin
                        state_n       = IDLE;
                        half_period_n = '0;
                        tone_en_n     = 1'b0;
                        note_index_n  = 2'd0;
                        busy_n        = 1'b0;
                        done_n        = 1'b1;
                    end else if (!GAP_EN) begin
                        note_index_n  = idx_inc;
                        half_period_n = note_val(idx_inc);
                        tone_en_n     = (note_val(idx_inc) != 24'd0);
                    end else begin
                        state_n   = GAP;
                        tone_en_n = 1'b0;
                    end
                end else if (state == GAP && cnt == GAP_LAST) begin
                    state_n       = NOTE;
                    cnt_n         = '0;
                    note_index_n  = idx_inc;
                    half_period_n = note_val(idx_inc);
                    tone_en_n     = (note_val(idx_inc) != 24'd0);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: dut_a uses gaps, dut_b is gapless with a rest note.
module tb_melody_sequencer;

    logic        clk12MHz = 1'b0;
    logic        rst_a, key_a, rst_b, key_b;
    logic [23:0] hp_a, hp_b;
    logic        ten_a, ten_b, busy_a, busy_b, done_a, done_b;
    logic [1:0]  idx_a, idx_b;

    int checks = 0;
    int errors = 0;

    always #5 clk12MHz = ~clk12MHz;

    melody_sequencer #(.DEBOUNCE_CYCLES(4), .NOTE_LEN(10), .GAP_LEN(3)) dut_a (
        .clk12MHz(clk12MHz), .rst(rst_a), .key1(key_a), .half_period(hp_a),
        .tone_en(ten_a), .note_index(idx_a), .busy(busy_a), .done(done_a));

    melody_sequencer #(.DEBOUNCE_CYCLES(4), .NOTE_LEN(10), .GAP_LEN(0), .NOTE1(0)) dut_b (
        .clk12MHz(clk12MHz), .rst(rst_b), .key1(key_b), .half_period(hp_b),
        .tone_en(ten_b), .note_index(idx_b), .busy(busy_b), .done(done_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk12MHz);
        #1;
    endtask

    task automatic idle(input int n);
        key_a = 1'b1;
        key_b = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int busy_cnt, ten_cnt, done_cnt, rise_cnt, gap_cnt, done_k;
        logic ten_prev;
        logic [23:0] exp_hp [4];
        exp_hp[0] = 24'd27272; exp_hp[1] = 24'd18202;
        exp_hp[2] = 24'd15306; exp_hp[3] = 24'd22933;

        // Reset with key held low
        rst_a = 1'b1; rst_b = 1'b1; key_a = 1'b0; key_b = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_half_period", hp_a, 0);
        chk("rst_tone_en", ten_a, 0);
        chk("rst_note_index", idx_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_b_busy", busy_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) chk("latency_busy_low_k7", busy_a, 0);
            if (k == 8) begin
                chk("latency_busy_k8", busy_a, 1);
                chk("latency_tone_en_k8", ten_a, 1);
                chk("latency_hp_k8", hp_a, 27272);
            end
        end
        key_a = 1'b1; rst_a = 1'b1;
        tick();
        chk("rst_mid_busy", busy_a, 0);
        rst_a = 1'b0;
        idle(10);

        // Full melody, 20-cycle key pulse
        busy_cnt = 0; ten_cnt = 0; done_cnt = 0; rise_cnt = 0; gap_cnt = 0; done_k = -1;
        ten_prev = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            key_a = (k <= 20) ? 1'b0 : 1'b1;
            tick();
            if (busy_a) busy_cnt++;
            if (ten_a) ten_cnt++;
            if (busy_a && !ten_a) gap_cnt++;
            if (done_a) begin done_cnt++; done_k = k; end
            if (ten_a && !ten_prev) begin
                if (rise_cnt < 4) chk($sformatf("melody_hp_note%0d", rise_cnt), hp_a, exp_hp[rise_cnt]);
                rise_cnt++;
            end
            ten_prev = ten_a;
            if (k == 8) chk("melody_first_busy", busy_a, 1);
            if (k == 18) begin
                chk("melody_gap_tone_en", ten_a, 0);
                chk("melody_gap_hp_hold", hp_a, 27272);
            end
            if (k == 21) chk("melody_note1_idx", idx_a, 1);
            if (k == 56) chk("melody_busy_last", busy_a, 1);
            if (k == 57) chk("melody_busy_fall", busy_a, 0);
        end
        chk("melody_busy_cycles", busy_cnt, 49);
        chk("melody_tone_cycles", ten_cnt, 40);
        chk("melody_gap_cycles", gap_cnt, 9);
        chk("melody_note_count", rise_cnt, 4);
        chk("melody_done_count", done_cnt, 1);
        chk("melody_done_cycle", done_k, 57);
        idle(5);

        // Bounce: 3 low, 2 high, 3 low
        busy_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            key_a = ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)) ? 1'b0 : 1'b1;
            tick();
            if (busy_a) busy_cnt++;
        end
        chk("bounce_no_busy", busy_cnt, 0);

        // Abort during note 2, then restart
        done_cnt = 0; busy_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            key_a = ((k <= 8) || (k >= 30 && k <= 37) || (k >= 50)) ? 1'b0 : 1'b1;
            tick();
            if (done_a) done_cnt++;
            if (k >= 37 && k <= 56 && busy_a) busy_cnt++;
            if (k == 36) begin
                chk("abort_pre_busy", busy_a, 1);
                chk("abort_pre_idx", idx_a, 2);
            end
            if (k == 37) begin
                chk("abort_busy", busy_a, 0);
                chk("abort_tone_en", ten_a, 0);
                chk("abort_hp", hp_a, 0);
                chk("abort_idx", idx_a, 0);
            end
            if (k == 57) begin
                chk("restart_busy", busy_a, 1);
                chk("restart_idx", idx_a, 0);
                chk("restart_hp", hp_a, 27272);
            end
        end
        chk("abort_idle_busy", busy_cnt, 0);
        chk("abort_no_done", done_cnt, 0);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        idle(10);

        // Gapless with rest on note 1 (dut_b)
        busy_cnt = 0; ten_cnt = 0; done_k = -1; done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            key_b = (k <= 8) ? 1'b0 : 1'b1;
            tick();
            if (busy_b) busy_cnt++;
            if (ten_b) ten_cnt++;
            if (done_b) begin done_cnt++; done_k = k; end
            if (k == 17) begin
                chk("gapless_note0_tone", ten_b, 1);
                chk("gapless_note0_idx", idx_b, 0);
            end
            if (k == 18 || k == 27) begin
                chk($sformatf("rest_idx_k%0d", k), idx_b, 1);
                chk($sformatf("rest_tone_k%0d", k), ten_b, 0);
                chk($sformatf("rest_hp_k%0d", k), hp_b, 0);
            end
            if (k == 28) begin
                chk("gapless_note2_idx", idx_b, 2);
                chk("gapless_note2_hp", hp_b, 15306);
                chk("gapless_note2_tone", ten_b, 1);
            end
        end
        chk("gapless_busy_cycles", busy_cnt, 40);
        chk("gapless_tone_cycles", ten_cnt, 30);
        chk("gapless_done_count", done_cnt, 1);
        chk("gapless_done_cycle", done_k, 48);
        idle(5);

        // Reset during the gap after note 0, key released
        busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            key_a = (k <= 8) ? 1'b0 : 1'b1;
            rst_a = (k == 19) ? 1'b1 : 1'b0;
            tick();
            if (k == 18) begin
                chk("midrst_in_gap_busy", busy_a, 1);
                chk("midrst_in_gap_tone", ten_a, 0);
            end
            if (k == 19) begin
                chk("midrst_busy", busy_a, 0);
                chk("midrst_hp", hp_a, 0);
                chk("midrst_idx", idx_a, 0);
                chk("midrst_tone", ten_a, 0);
            end
            if (k >= 19 && busy_a) busy_cnt++;
            if (k >= 19 && done_a) done_cnt++;
        end
        chk("midrst_stays_idle", busy_cnt, 0);
        chk("midrst_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
